// File: rtl/booth_mult_seq_if.sv
// Handshake/operand bundle for booth_mult_seq: request side (master) drives
// start and operands, multiplier side (slave) returns product and status.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;
    logic                 done;

    modport master (
        output start, signed_mode, x, y,
        input  p, busy, done
    );

    modport slave (
        input  start, signed_mode, x, y,
        output p, busy, done
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, full 2*WIDTH product, signed/unsigned per operation.
// Define BOOTH_RADIX4_EN for modified (radix-4) Booth; otherwise radix-2.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    booth_mult_seq_if.slave   bus
);
    // Operands are extended by one bit so unsigned values become non-negative signed ones.
    localparam int E  = WIDTH + 1;
`ifdef BOOTH_RADIX4_EN
    localparam int QW   = 2 * ((E + 1) / 2);
    localparam int ITER = QW / 2;
    localparam int SH   = 2;
`else
    localparam int QW   = E;
    localparam int ITER = E;
    localparam int SH   = 1;
`endif
    localparam int AW = E + 1;
    localparam int SW = E + 2;
    localparam int TW = SW + QW + 1;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [E-1:0]         m_reg;
    logic [AW-1:0]        a_reg;
    logic [QW-1:0]        q_reg;
    logic                 q1_reg;
    logic [CW-1:0]        count_reg;
    logic [2*WIDTH-1:0]   p_reg;

    logic [E-1:0]         x_ext;
    logic [E-1:0]         y_ext;
    logic [QW-1:0]        q_load;
    logic signed [SW-1:0] a_sx;
    logic signed [SW-1:0] m_sx;
    logic signed [SW-1:0] addend;
    logic signed [SW-1:0] sum;
    logic signed [TW-1:0] cat;
    logic signed [TW-1:0] shifted;
    logic [AW-1:0]        a_step;
    logic [QW-1:0]        q_step;
    logic                 q1_step;
    logic [2*WIDTH-1:0]   p_step;
    logic                 last_iter;

    assign x_ext  = bus.signed_mode ? {bus.x[WIDTH-1], bus.x} : {1'b0, bus.x};
    assign y_ext  = bus.signed_mode ? {bus.y[WIDTH-1], bus.y} : {1'b0, bus.y};
    assign q_load = QW'($signed(y_ext));

    assign last_iter = (count_reg == CW'(1));

    always_comb begin
        a_sx   = SW'($signed(a_reg));
        m_sx   = SW'($signed(m_reg));
        addend = '0;
`ifdef BOOTH_RADIX4_EN
        case ({q_reg[1:0], q1_reg})
            3'b001, 3'b010: addend = m_sx;
            3'b011:         addend = m_sx <<< 1;
            3'b100:         addend = -(m_sx <<< 1);
            3'b101, 3'b110: addend = -m_sx;
            default:        addend = '0;
        endcase
`else
        case ({q_reg[0], q1_reg})
            2'b01:   addend = m_sx;
            2'b10:   addend = -m_sx;
            default: addend = '0;
        endcase
`endif
        // Sum is one bit wider than A so the +/-2M step never wraps before the shift.
        sum     = a_sx + addend;
        cat     = {sum, q_reg, q1_reg};
        shifted = cat >>> SH;
        a_step  = AW'(shifted >> (QW + 1));
        q_step  = QW'(shifted >> 1);
        q1_step = shifted[0];
        p_step  = (2*WIDTH)'({a_step, q_step});
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            q1_reg    <= 1'b0;
            count_reg <= '0;
            p_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        m_reg     <= x_ext;
                        a_reg     <= '0;
                        q_reg     <= q_load;
                        q1_reg    <= 1'b0;
                        count_reg <= CW'(ITER);
                    end
                end
                CALC: begin
                    a_reg     <= a_step;
                    q_reg     <= q_step;
                    q1_reg    <= q1_step;
                    count_reg <= count_reg - CW'(1);
                    if (last_iter) begin
                        p_reg <= p_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p    = p_reg;
    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: WIDTH=8 scenarios plus exhaustive WIDTH=4 sweep.
module tb_booth_mult_seq;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER8 = 5;
    localparam int ITER4 = 3;
`else
    localparam int ITER8 = 9;
    localparam int ITER4 = 5;
`endif
    localparam int LAT_LIMIT = 40;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    booth_mult_seq_if #(.WIDTH(8)) bus8 ();
    booth_mult_seq_if #(.WIDTH(4)) bus4 ();

    booth_mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    booth_mult_seq #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request at WIDTH=8 and wait (bounded) for done; returns in IDLE.
    task automatic run8(input bit sm, input logic [7:0] xa, input logic [7:0] ya,
                        output logic [15:0] pr, output int lat, output bit busy_gap);
        bus8.signed_mode = sm;
        bus8.x = xa;
        bus8.y = ya;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.x = ~xa;
        bus8.y = ~ya;
        bus8.signed_mode = ~sm;
        lat = 0;
        busy_gap = 1'b0;
        while (bus8.done !== 1'b1 && lat < LAT_LIMIT) begin
            if (bus8.busy !== 1'b1) busy_gap = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (bus8.busy !== 1'b1) busy_gap = 1'b1;
        pr = bus8.p;
        $display("w8 sm=%0d x=%02h y=%02h -> p=%04h lat=%0d", sm, xa, ya, pr, lat);
        @(posedge clk); #1;
    endtask

    task automatic run4(input bit sm, input logic [3:0] xa, input logic [3:0] ya,
                        output logic [7:0] pr, output int lat);
        bus4.signed_mode = sm;
        bus4.x = xa;
        bus4.y = ya;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        bus4.x = ~xa;
        bus4.y = ~ya;
        lat = 0;
        while (bus4.done !== 1'b1 && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        pr = bus4.p;
        $display("w4 sm=%0d x=%01h y=%01h -> p=%02h lat=%0d", sm, xa, ya, pr, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus8.p !== 16'h0000) begin n_fail++; $display("FAIL reset_p8 got=%h exp=0000", bus8.p); end
        n_checks++;
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got=%b exp=0", bus8.busy); end
        n_checks++;
        if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL reset_done8 got=%b exp=0", bus8.done); end
        n_checks++;
        if (bus4.p !== 8'h00 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_w4 got p=%h busy=%b done=%b exp 00/0/0", bus4.p, bus4.busy, bus4.done);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_signed_basic();
        logic [15:0] pr; int lat; bit gap;
        run8(1'b1, 8'hFD, 8'h05, pr, lat, gap);
        n_checks++;
        if (pr !== 16'hFFF1) begin n_fail++; $display("FAIL m3x5_p got=%h exp=fff1", pr); end
        n_checks++;
        if (lat != ITER8) begin n_fail++; $display("FAIL m3x5_latency got=%0d exp=%0d", lat, ITER8); end
        n_checks++;
        if (gap) begin n_fail++; $display("FAIL m3x5_busy got=gap exp=busy_throughout"); end
    endtask

    task automatic test_extremes();
        logic [15:0] pr; int lat; bit gap;
        run8(1'b0, 8'hFF, 8'hFF, pr, lat, gap);
        n_checks++;
        if (pr !== 16'hFE01) begin n_fail++; $display("FAIL umax_p got=%h exp=fe01", pr); end
        n_checks++;
        if (lat != ITER8) begin n_fail++; $display("FAIL umax_latency got=%0d exp=%0d", lat, ITER8); end
        run8(1'b1, 8'h80, 8'h80, pr, lat, gap);
        n_checks++;
        if (pr !== 16'h4000) begin n_fail++; $display("FAIL smin_p got=%h exp=4000", pr); end
        run8(1'b1, 8'h00, 8'h5A, pr, lat, gap);
        n_checks++;
        if (pr !== 16'h0000 || lat != ITER8) begin
            n_fail++; $display("FAIL zero_x got p=%h lat=%0d exp p=0000 lat=%0d", pr, lat, ITER8);
        end
    endtask

    task automatic test_mode_select();
        logic [15:0] pr; int lat; bit gap;
        run8(1'b0, 8'h80, 8'h02, pr, lat, gap);
        n_checks++;
        if (pr !== 16'h0100) begin n_fail++; $display("FAIL unsigned_80x02 got=%h exp=0100", pr); end
        run8(1'b1, 8'h80, 8'h02, pr, lat, gap);
        n_checks++;
        if (pr !== 16'hFF00) begin n_fail++; $display("FAIL signed_80x02 got=%h exp=ff00", pr); end
    endtask

    task automatic test_busy_ignore();
        int waited;
        int dones;
        int extra;
        bus8.signed_mode = 1'b0;
        bus8.x = 8'h07;
        bus8.y = 8'h07;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        waited = 0;
        while (bus8.done !== 1'b1 && waited < LAT_LIMIT) begin
            @(posedge clk); #1;
            waited++;
        end
        dones = (bus8.done === 1'b1) ? 1 : 0;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        extra = 0;
        for (int i = 0; i < ITER8 + 3; i++) begin
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
            @(posedge clk); #1;
        end
        $display("w8 busy-ignore 7x7 -> p=%04h extra_active_cycles=%0d", bus8.p, extra);
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL ignore_first_done got=%0d exp=1", dones); end
        n_checks++;
        if (extra != 0) begin n_fail++; $display("FAIL ignore_extra_activity got=%0d exp=0", extra); end
        n_checks++;
        if (bus8.p !== 16'h0031) begin n_fail++; $display("FAIL ignore_p got=%h exp=0031", bus8.p); end
    endtask

    task automatic test_reset_midop();
        logic [15:0] pr; int lat; bit gap;
        int dones;
        bus8.signed_mode = 1'b0;
        bus8.x = 8'h12;
        bus8.y = 8'h34;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy_before got=%b exp=1", bus8.busy); end
        reset = 1'b1;
        #2;
        n_checks++;
        if (bus8.p !== 16'h0000 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            n_fail++; $display("FAIL midop_reset got p=%h busy=%b done=%b exp 0000/0/0", bus8.p, bus8.busy, bus8.done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < ITER8 + 3; i++) begin
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL midop_no_done got=%0d exp=0", dones); end
        run8(1'b0, 8'h02, 8'h03, pr, lat, gap);
        n_checks++;
        if (pr !== 16'h0006 || lat != ITER8) begin
            n_fail++; $display("FAIL after_reset_2x3 got p=%h lat=%0d exp p=0006 lat=%0d", pr, lat, ITER8);
        end
    endtask

    task automatic test_back_to_back_w4();
        logic [7:0] pr;
        logic [7:0] exp_p;
        int lat;
        int a, b, prod;
        for (int sm = 0; sm < 2; sm++) begin
            for (int xi = 0; xi < 16; xi++) begin
                for (int yi = 0; yi < 16; yi++) begin
                    run4(sm[0], xi[3:0], yi[3:0], pr, lat);
                    a = (sm == 1 && xi >= 8) ? xi - 16 : xi;
                    b = (sm == 1 && yi >= 8) ? yi - 16 : yi;
                    prod = a * b;
                    exp_p = prod[7:0];
                    n_checks++;
                    if (pr !== exp_p) begin
                        n_fail++; $display("FAIL w4_p sm=%0d x=%0d y=%0d got=%h exp=%h", sm, xi, yi, pr, exp_p);
                    end
                    n_checks++;
                    if (lat != ITER4) begin
                        n_fail++; $display("FAIL w4_latency sm=%0d x=%0d y=%0d got=%0d exp=%0d", sm, xi, yi, lat, ITER4);
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.x = '0; bus8.y = '0;
        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.x = '0; bus4.y = '0;
        test_reset();
        test_signed_basic();
        test_extremes();
        test_mode_select();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back_w4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
